gtwizard_0_word_align: RTL

Receive-side 64b/67b word-alignment (block lock) stage. It sits between the GT receive gearbox outputs and `gtwizard_0_DESCRAMBLER`. It checks the 2-bit sync header of each gearbox word, pulses the gearbox slip request until header alignment is found, and declares lock after a full window of good headers. Data, header and valid pass through with one register stage; valid is qualified by lock so the descrambler only sees aligned words.

---
 rtl/gtwizard_0_pkg.sv | 20 ++
 rtl/gtwizard_0_word_align.sv | 127 ++++++++++++
 2 files changed

// File: rtl/gtwizard_0_pkg.sv
// Shared definitions for the receive word-alignment stage: FSM state
// encodings, sync-header constants and a header classification helper.
package gtwizard_0_pkg;

   typedef enum logic [1:0] {
      ST_RESET         = 2'b00,
      ST_TEST_UNLOCKED = 2'b01,
      ST_TEST_LOCKED   = 2'b10,
      ST_SLIP_WAIT     = 2'b11
   } align_state_t;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   // A sync header is legal only as one of the two defined codes.
   function automatic logic header_good(input logic [1:0] hdr);
      return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
   endfunction

endpackage

// File: rtl/gtwizard_0_word_align.sv
// 64b/67b receive block-lock stage. Tests gearbox sync headers, requests
// gearbox slips until the headers line up, and declares lock after a full
// window of good headers. Data, header and valid are registered once; valid
// is qualified by lock so downstream logic only sees aligned words.
module gtwizard_0_word_align
   import gtwizard_0_pkg::*;
#(
   parameter int RX_DATA_WIDTH      = 64,
   parameter int SH_CNT_MAX         = 64,
   parameter int SH_INVALID_CNT_MAX = 16,
   parameter int SLIP_WAIT_CYCLES   = 32
) (
   input  logic                     USER_CLK,
   input  logic                     SYSTEM_RESET,
   input  logic [RX_DATA_WIDTH-1:0] DATA_IN,
   input  logic [1:0]               HEADER_IN,
   input  logic                     HEADER_VALID_IN,
   input  logic                     DATA_VALID_IN,
   output logic [RX_DATA_WIDTH-1:0] DATA_OUT,
   output logic [1:0]               HEADER_OUT,
   output logic                     DATA_VALID_OUT,
   output logic                     BLOCK_LOCK,
   output logic                     RXGEARBOXSLIP_OUT
);

   localparam int SH_W   = $clog2(SH_CNT_MAX) + 1;
   localparam int INV_W  = $clog2(SH_INVALID_CNT_MAX) + 1;
   localparam int SLIP_W = $clog2(SLIP_WAIT_CYCLES) + 1;

   localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_MAX - 1);
   localparam logic [INV_W-1:0]  INV_LIMIT = INV_W'(SH_INVALID_CNT_MAX);
   localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT_CYCLES - 1);

   align_state_t       state;
   logic [SH_W-1:0]    sh_cnt;
   logic [INV_W-1:0]   sh_invalid_cnt;
   logic [SLIP_W-1:0]  slip_cnt;
   logic               slip_p1;
   logic               hdr_ok;
   logic [INV_W-1:0]   inv_next;

   assign hdr_ok   = header_good(HEADER_IN);
   assign inv_next = sh_invalid_cnt + INV_W'(!hdr_ok);

   // Block-lock state machine with its counters and the registered slip pulse.
   always_ff @(posedge USER_CLK) begin
      if (SYSTEM_RESET) begin
         state          <= ST_RESET;
         sh_cnt         <= '0;
         sh_invalid_cnt <= '0;
         slip_cnt       <= '0;
         slip_p1        <= 1'b0;
      end else begin
         slip_p1 <= 1'b0;
         case (state)
            ST_RESET: begin
               sh_cnt         <= '0;
               sh_invalid_cnt <= '0;
               slip_cnt       <= '0;
               state          <= ST_TEST_UNLOCKED;
            end
            ST_TEST_UNLOCKED: begin
               if (HEADER_VALID_IN) begin
                  if (!hdr_ok) begin
                     slip_p1        <= 1'b1;
                     sh_cnt         <= '0;
                     sh_invalid_cnt <= '0;
                     slip_cnt       <= '0;
                     state          <= ST_SLIP_WAIT;
                  end else if (sh_cnt == SH_LAST) begin
                     sh_cnt         <= '0;
                     sh_invalid_cnt <= '0;
                     state          <= ST_TEST_LOCKED;
                  end else begin
                     sh_cnt <= sh_cnt + 1'b1;
                  end
               end
            end
            ST_TEST_LOCKED: begin
               if (HEADER_VALID_IN) begin
                  // Reaching the invalid limit outranks the end-of-window reset.
                  if (!hdr_ok && (inv_next == INV_LIMIT)) begin
                     slip_p1        <= 1'b1;
                     sh_cnt         <= '0;
                     sh_invalid_cnt <= '0;
                     slip_cnt       <= '0;
                     state          <= ST_SLIP_WAIT;
                  end else if (sh_cnt == SH_LAST) begin
                     sh_cnt         <= '0;
                     sh_invalid_cnt <= '0;
                  end else begin
                     sh_cnt         <= sh_cnt + 1'b1;
                     sh_invalid_cnt <= inv_next;
                  end
               end
            end
            ST_SLIP_WAIT: begin
               // Headers are ignored while the gearbox settles after a slip.
               if (slip_cnt == SLIP_LAST) begin
                  slip_cnt <= '0;
                  state    <= ST_TEST_UNLOCKED;
               end else begin
                  slip_cnt <= slip_cnt + 1'b1;
               end
            end
            default: state <= ST_RESET;
         endcase
      end
   end

   assign BLOCK_LOCK        = (state == ST_TEST_LOCKED);
   assign RXGEARBOXSLIP_OUT = slip_p1;

   // One-cycle pass-through of data and header; valid gated by current lock.
   always_ff @(posedge USER_CLK) begin
      if (SYSTEM_RESET) begin
         DATA_OUT       <= '0;
         HEADER_OUT     <= '0;
         DATA_VALID_OUT <= 1'b0;
      end else begin
         DATA_OUT       <= DATA_IN;
         HEADER_OUT     <= HEADER_IN;
         DATA_VALID_OUT <= DATA_VALID_IN & BLOCK_LOCK;
      end
   end

endmodule
